// File: rtl/audio_pkg.sv
// Shared audio-path definitions: PWM resolution, error-feedback precision
// and the sample type exchanged with the tone generator.
package audio_pkg;
    localparam int unsigned SAMPLE_BITS = 7;
    localparam int unsigned EXTRA_BITS  = 8;
    localparam int unsigned IN_W        = SAMPLE_BITS + EXTRA_BITS;
    localparam int unsigned FRAME_LEN   = 1 << SAMPLE_BITS;
    localparam int unsigned SUM_W       = IN_W + 1;

    typedef logic [IN_W-1:0] sample_t;
endpackage

// File: rtl/pwm_dac_if.sv
// Sample stream from the tone generator into the PWM DAC (valid/ready).
interface pwm_dac_if
    import audio_pkg::*;
#(
    parameter int unsigned W = IN_W
);
    logic [W-1:0] in_sample;
    logic         in_valid;
    logic         in_ready;

    modport master (output in_sample, output in_valid, input in_ready);
    modport slave  (input in_sample, input in_valid, output in_ready);
endinterface

// File: rtl/sample_quantizer.sv
// First-order error-feedback quantizer: splits level+err into duty and
// the fractional residue carried into the next frame.
module sample_quantizer
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS = audio_pkg::SAMPLE_BITS,
    parameter int unsigned EXTRA_BITS  = audio_pkg::EXTRA_BITS
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load_i,
    input  logic                            mute_i,
    input  logic [SAMPLE_BITS+EXTRA_BITS-1:0] level_i,
    output logic [SAMPLE_BITS:0]            duty_o
);
    localparam int unsigned Q_SUM_W = SAMPLE_BITS + EXTRA_BITS + 1;

    logic [Q_SUM_W-1:0]    sum;
    logic [EXTRA_BITS-1:0] err_q;
    logic [SAMPLE_BITS:0]  duty_q;

    always_comb begin
        sum = Q_SUM_W'(level_i) + Q_SUM_W'(err_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty_q <= '0;
            err_q  <= '0;
        end else if (load_i) begin
            if (mute_i) begin
                duty_q <= '0;
                err_q  <= '0;
            end else begin
                duty_q <= sum[Q_SUM_W-1:EXTRA_BITS];
                err_q  <= sum[EXTRA_BITS-1:0];
            end
        end
    end

    assign duty_o = duty_q;
endmodule

// File: rtl/pwm_dac.sv
// Audio PWM output stage: one-entry sample buffer, volume shift, mute,
// underrun accounting and a fixed 2^SAMPLE_BITS-clock PWM frame.
module pwm_dac
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS = audio_pkg::SAMPLE_BITS,
    parameter int unsigned EXTRA_BITS  = audio_pkg::EXTRA_BITS
) (
    input  logic        clk,
    input  logic        rst_n,
    pwm_dac_if.slave    in_if,
    input  logic [1:0]  vol,
    input  logic        mute,
    output logic        sample_req,
    output logic        pwm,
    output logic        underrun,
    output logic [7:0]  underrun_count
);
    localparam int unsigned W = SAMPLE_BITS + EXTRA_BITS;

    logic [SAMPLE_BITS-1:0] cnt_q;
    logic [W-1:0]           buf_q;
    logic                   buf_valid_q;
    logic [W-1:0]           last_q;
    logic [W-1:0]           last_d;
    logic                   sample_req_q;
    logic                   underrun_q;
    logic [7:0]             urun_cnt_q;
    logic [SAMPLE_BITS:0]   duty;
    logic                   boundary;
    logic                   accept;

    assign boundary = (cnt_q == '1);
    assign accept   = in_if.in_valid && !buf_valid_q;

    // The quantizer must see the freshly consumed sample in the same cycle
    // that `last` is updated, so it is fed the next-state value.
    always_comb begin
        last_d = last_q;
        if (buf_valid_q) begin
            last_d = buf_q >> vol;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            buf_q        <= '0;
            buf_valid_q  <= 1'b0;
            last_q       <= '0;
            sample_req_q <= 1'b0;
            underrun_q   <= 1'b0;
            urun_cnt_q   <= '0;
        end else begin
            cnt_q        <= cnt_q + 1'b1;
            sample_req_q <= boundary;
            underrun_q   <= boundary && !buf_valid_q;
            if (boundary) begin
                if (buf_valid_q) begin
                    last_q      <= last_d;
                    buf_valid_q <= 1'b0;
                end else if (urun_cnt_q != '1) begin
                    urun_cnt_q <= urun_cnt_q + 1'b1;
                end
            end
            // accept is only possible with an empty buffer, so it never
            // collides with the consume-clear above.
            if (accept) begin
                buf_q       <= in_if.in_sample;
                buf_valid_q <= 1'b1;
            end
        end
    end

    sample_quantizer #(
        .SAMPLE_BITS (SAMPLE_BITS),
        .EXTRA_BITS  (EXTRA_BITS)
    ) u_quant (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (boundary),
        .mute_i  (mute),
        .level_i (last_d),
        .duty_o  (duty)
    );

    assign in_if.in_ready = !buf_valid_q;
    assign pwm            = ({1'b0, cnt_q} < duty);
    assign sample_req     = sample_req_q;
    assign underrun       = underrun_q;
    assign underrun_count = urun_cnt_q;
endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac: frame timing, quantizer sequences, mute,
// volume, backpressure, underrun saturation and mid-frame reset.
module tb_pwm_dac;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] vol;
    logic       mute;
    logic       sample_req;
    logic       pwm;
    logic       underrun;
    logic [7:0] underrun_count;

    int n_checks = 0;
    int n_pass   = 0;

    pwm_dac_if #(.W(15)) sif ();

    pwm_dac dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_if          (sif),
        .vol            (vol),
        .mute           (mute),
        .sample_req     (sample_req),
        .pwm            (pwm),
        .underrun       (underrun),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          feed;
        logic [14:0] s;
        logic [1:0]  v;
        bit          m;
        int          hi;
        int          err;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output int n, output bit pwm_seen, output bit rdy_low);
        n = 0;
        pwm_seen = 1'b0;
        rdy_low = 1'b0;
        while (n < 200) begin
            step();
            n++;
            if (pwm) pwm_seen = 1'b1;
            if (!sif.in_ready) rdy_low = 1'b1;
            if (sample_req) break;
        end
    endtask

    task automatic run_frame(input bit feed, input logic [14:0] s, output int hi);
        hi = 0;
        for (int i = 0; i < 128; i++) begin
            if (i == 0 && feed) begin
                sif.in_sample = s;
                sif.in_valid  = 1'b1;
            end
            hi += int'(pwm);
            step();
            if (i == 0) sif.in_valid = 1'b0;
        end
    endtask

    initial begin
        int n;
        int hi;
        bit pwm_seen;
        bit rdy_low;
        bit prev_fed;

        vecs[0]  = '{1'b1, 15'h4000, 2'd0, 1'b0,   0,   0};
        vecs[1]  = '{1'b1, 15'h4000, 2'd0, 1'b0,  64,   0};
        vecs[2]  = '{1'b1, 15'h4000, 2'd2, 1'b0,  64,   0};
        vecs[3]  = '{1'b1, 15'h0080, 2'd0, 1'b0,  16,   0};
        vecs[4]  = '{1'b1, 15'h0080, 2'd0, 1'b0,   0, 128};
        vecs[5]  = '{1'b1, 15'h0080, 2'd0, 1'b0,   1,   0};
        vecs[6]  = '{1'b1, 15'h0080, 2'd0, 1'b0,   0, 128};
        vecs[7]  = '{1'b1, 15'h7FFF, 2'd0, 1'b0,   1,   0};
        vecs[8]  = '{1'b1, 15'h7FFF, 2'd0, 1'b0, 127, 255};
        vecs[9]  = '{1'b1, 15'h4000, 2'd0, 1'b0, 128, 254};
        vecs[10] = '{1'b1, 15'h4000, 2'd0, 1'b1,  64, 254};
        vecs[11] = '{1'b1, 15'h4000, 2'd0, 1'b0,   0,   0};
        vecs[12] = '{1'b0, 15'h0000, 2'd0, 1'b0,  64,   0};

        rst_n         = 1'b0;
        vol           = 2'd0;
        mute          = 1'b0;
        sif.in_sample = '0;
        sif.in_valid  = 1'b0;
        repeat (3) step();

        check("rst_pwm", 32'(pwm), 0);
        check("rst_in_ready", 32'(sif.in_ready), 1);
        check("rst_sample_req", 32'(sample_req), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_urun_cnt", 32'(underrun_count), 0);

        // Idle after reset: first request and underrun 128 edges later.
        rst_n = 1'b1;
        wait_frame(n, pwm_seen, rdy_low);
        check("first_req_latency", n, 128);
        check("first_underrun", 32'(underrun), 1);
        check("idle_pwm_seen", 32'(pwm_seen), 0);
        check("idle_ready_low", 32'(rdy_low), 0);
        check("urun_cnt_1", 32'(underrun_count), 1);
        wait_frame(n, pwm_seen, rdy_low);
        check("frame2_len", n, 128);
        wait_frame(n, pwm_seen, rdy_low);
        check("frame3_len", n, 128);
        check("urun_cnt_3", 32'(underrun_count), 3);

        prev_fed = 1'b0;
        for (int k = 0; k < 13; k++) begin
            vol  = vecs[k].v;
            mute = vecs[k].m;
            check($sformatf("v%0d_req", k), 32'(sample_req), 1);
            check($sformatf("v%0d_underrun", k), 32'(underrun), prev_fed ? 0 : 1);
            check($sformatf("v%0d_err", k), 32'(dut.u_quant.err_q), vecs[k].err);
            run_frame(vecs[k].feed, vecs[k].s, hi);
            check($sformatf("v%0d_high", k), hi, vecs[k].hi);
            prev_fed = vecs[k].feed;
        end
        mute = 1'b0;
        vol  = 2'd0;

        check("starve_underrun", 32'(underrun), 1);
        check("urun_cnt_4", 32'(underrun_count), 4);
        for (int f = 0; f < 300; f++) run_frame(1'b0, '0, hi);
        check("sat_req_aligned", 32'(sample_req), 1);
        check("urun_cnt_sat", 32'(underrun_count), 255);
        run_frame(1'b0, '0, hi);
        check("sat_repeat_high", hi, 64);
        check("urun_cnt_hold", 32'(underrun_count), 255);

        // Backpressure: A accepted at once, B held until the buffer frees.
        sif.in_sample = 15'h2000;
        sif.in_valid  = 1'b1;
        step();
        check("bp_ready_low", 32'(sif.in_ready), 0);
        sif.in_sample = 15'h6000;
        repeat (127) step();
        check("bp_req", 32'(sample_req), 1);
        check("bp_ready_after_boundary", 32'(sif.in_ready), 1);
        hi = 0;
        for (int i = 0; i < 128; i++) begin
            hi += int'(pwm);
            step();
            if (i == 0) begin
                check("bp_b_accepted", 32'(sif.in_ready), 0);
                sif.in_valid = 1'b0;
            end
        end
        check("bp_a_high", hi, 32);
        run_frame(1'b0, '0, hi);
        check("bp_b_high", hi, 96);

        // Mid-frame reset with a full buffer.
        sif.in_sample = 15'h1000;
        sif.in_valid  = 1'b1;
        step();
        sif.in_valid  = 1'b0;
        check("mr_buf_full", 32'(sif.in_ready), 0);
        repeat (39) step();
        check("mr_pwm_before", 32'(pwm), 1);
        rst_n = 1'b0;
        step();
        check("mr_pwm_cleared", 32'(pwm), 0);
        check("mr_ready", 32'(sif.in_ready), 1);
        check("mr_urun_cnt", 32'(underrun_count), 0);
        rst_n = 1'b1;
        wait_frame(n, pwm_seen, rdy_low);
        check("mr_req_latency", n, 128);
        check("mr_buf_discarded", 32'(underrun), 1);
        check("mr_pwm_seen", 32'(pwm_seen), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pwm_dac.md
# pwm_dac

Output stage of the audio path: takes extended-precision samples from the tone generator over a valid/ready handshake and turns them into a fixed-rate PWM bitstream for the board's audio pin. Each PWM frame is 2^SAMPLE_BITS clocks long, which gives 128 clocks and about 195 kHz at 25 MHz. The low-order EXTRA_BITS are not truncated; first-order error feedback carries them into the next frame. The block adds a one-entry input buffer, volume shift, mute, and underrun detection so the upstream generator needs no PWM timing of its own.

## Interface
- SAMPLE_BITS, 7: PWM resolution; frame length = 2^SAMPLE_BITS clocks.
- EXTRA_BITS, 8: fractional bits carried by error feedback.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_sample  in  SAMPLE_BITS+EXTRA_BITS (15)  unsigned sample, full scale 0x7FFF.
- in_valid  in  1  in_sample is valid.
- in_ready  out  1  input buffer is empty.
- vol  in  2  attenuation: sample is right-shifted by vol at consumption.
- mute  in  1  level input, sampled at the frame boundary.
- sample_req  out  1  one-cycle pulse at the start of each frame.
- pwm  out  1  PWM output.
- underrun  out  1  one-cycle pulse in the first cycle of a frame that had no new sample.
- underrun_count  out  8  saturating count of underruns.

## Operation
- Frame counter `cnt` runs 0..2^SAMPLE_BITS−1 and wraps. The boundary is the cycle with cnt == MAX (127).
- pwm = (cnt < duty). duty is SAMPLE_BITS+1 bits wide, range 0..128; duty = 128 drives pwm high for the whole frame.
- Input buffer:
  - Holds one sample in `buf` and a `buf_valid` flag. in_ready = !buf_valid.
  - A sample is accepted when in_valid && in_ready; `buf` and vol are captured later, at consumption.
- Boundary with buf_valid = 1:
  - `last` <= buf >> vol.
  - buf_valid <= 0.
  - The quantizer runs on `last`.
- Boundary with buf_valid = 0:
  - `last` is kept and the quantizer runs on it again.
  - The underrun pulse is issued.
  - underrun_count increments and saturates at 255.
- Acceptance in the boundary cycle itself fills the buffer but does not count as present at that boundary, so it is an underrun. The buffer is then consumed at the next boundary.
- Quantizer:
  - sum = last + err, where last and err are zero-extended to 16 bits.
  - duty <= sum[15:8] (SAMPLE_BITS+1 bits).
  - err <= sum[7:0].
  - The maximum sum is 32767 + 255 = 33022, so duty never exceeds 128.
- Mute: if mute = 1 at the boundary, duty <= 0 and err <= 0.
  - Buffer consumption and `last` update still occur.
  - Underrun accounting is unchanged.
- Reset mid-frame: all state is cleared immediately and any sample in the buffer is discarded.

## Timing
- Reset values:
  - Internal state: cnt = 0, duty = 0, err = 0, last = 0, buf_valid = 0, underrun_count = 0.
  - Outputs: pwm = 0, in_ready = 1, sample_req = 0, underrun = 0.
- sample_req and underrun are registered.
  - Both are set on the boundary edge, so they are high during the cnt == 0 cycle only.
  - No sample_req is issued in the first frame after reset.
- Latency:
  - A sample accepted at cycle t (t in a frame, not at its boundary) is consumed at that frame's boundary.
  - It affects pwm from the next cnt == 0.
  - in_ready rises in the cycle after the boundary.
- in_ready is a pure function of buf_valid, with no combinational path from in_valid.
- vol changes take effect on the next consumed sample only.

## Structure
- Shared package `audio_pkg`:
  - SAMPLE_BITS, EXTRA_BITS.
  - Derived FRAME_LEN and SUM_W.
  - The sample type, shared with the tone generator.
- Sub-module `sample_quantizer`:
  - Contains the err/duty registers, the mute clear, and the sum/split arithmetic.
  - Triggered by a load strobe at the boundary.
- The top level holds the counter, buffer/handshake, and underrun logic.

## Test plan
- Reset, then idle with in_valid = 0:
  - pwm stays 0 and in_ready = 1.
  - First sample_req and first underrun both occur at cycle 128 after release.
  - underrun_count reaches 3 after 3 frames.
- Constant 0x4000, vol = 0, fed on every sample_req:
  - Steady state pwm is high for exactly 64 of 128 cycles.
  - err stays 0.
  - The same stream with vol = 2 gives 16 high cycles.
- Constant 0x0080:
  - High-time alternates 0, 1, 0, 1 cycles per frame.
  - err alternates 128, 0.
- Constant 0x7FFF:
  - First frame has 127 high cycles with err = 255.
  - Second frame has 128 high cycles (pwm never low) with err = 254.
- Backpressure:
  - in_valid is held high with samples A and B.
  - A is accepted at once and in_ready drops.
  - B is accepted in the cycle after the boundary.
  - A's duty appears at the next cnt == 0.
- Edge cases:
  - Mute asserted with 0x4000: duty is 0 next frame and err is 0; releasing mute restores 64.
  - Stopping input for 300 frames saturates underrun_count at 255 and keeps repeating the last duty.
  - Asserting rst_n low mid-frame clears pwm and the buffer the next cycle.
